// File: rtl/static_frame_writer.sv
// Write side of the static-frame BRAM handshake: stores one raster-order frame, then freezes it
// and holds static_bram_rdy until the correlator raises max_ready.
module static_frame_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tracking_mode,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              max_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [PIX_W-1:0]  bram_wdata,
    output logic              static_bram_rdy,
    output logic              frame_err,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              max_ready_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [PIX_W-1:0]  wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic [7:0]        drop_q, drop_d;

    logic sof;
    logic max_rise;

    assign sof      = pix_valid & pix_sof;
    // Only a fresh rising edge releases READY; a level left over from the last search does not.
    assign max_rise = max_ready & ~max_ready_q;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        drop_d  = drop_q;

        if (!tracking_mode) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        we_d    = 1'b1;
                        waddr_d = '0;
                        wdata_d = pix_data;
                        addr_d  = ADDR_W'(1);
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (pix_valid) begin
                        we_d    = 1'b1;
                        wdata_d = pix_data;
                        if (pix_sof) begin
                            // Early SOF: flag it and restart the frame with this pixel at address 0.
                            err_d   = 1'b1;
                            waddr_d = '0;
                            addr_d  = ADDR_W'(1);
                        end else begin
                            waddr_d = addr_q;
                            if (addr_q == LAST_ADDR) begin
                                addr_d  = '0;
                                state_d = READY;
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
                    end
                end
                READY: begin
                    if (max_rise) begin
                        state_d = IDLE;
                    end else begin
                        rdy_d = 1'b1;
                        if (sof && drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            max_ready_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            max_ready_q <= max_ready;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
        end
    end

    assign bram_we         = we_q;
    assign bram_waddr      = waddr_q;
    assign bram_wdata      = wdata_q;
    assign static_bram_rdy = rdy_q;
    assign frame_err       = err_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_static_frame_writer.sv
// Self-checking bench for static_frame_writer: 8x4 frame for the protocol cases, plus a
// 640x480 instance exercising address sequencing across line boundaries.
module tb_static_frame_writer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        tracking_mode;
    logic        pix_valid;
    logic        pix_sof;
    logic [3:0]  pix_data;
    logic        max_ready;
    logic        bram_we;
    logic [18:0] bram_waddr;
    logic [3:0]  bram_wdata;
    logic        static_bram_rdy;
    logic        frame_err;
    logic [7:0]  drop_count;

    logic        b_valid;
    logic        b_sof;
    logic [3:0]  b_data;
    logic        b_we;
    logic [18:0] b_waddr;
    logic [3:0]  b_wdata;
    logic        b_rdy;
    logic        b_err;
    logic [7:0]  b_drop;

    always #5 clk = ~clk;

    static_frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(19), .PIX_W(4)) dut (
        .clk(clk), .rst(rst), .tracking_mode(tracking_mode),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .max_ready(max_ready), .bram_we(bram_we), .bram_waddr(bram_waddr),
        .bram_wdata(bram_wdata), .static_bram_rdy(static_bram_rdy),
        .frame_err(frame_err), .drop_count(drop_count)
    );

    static_frame_writer #(.WIDTH(640), .HEIGHT(480), .ADDR_W(19), .PIX_W(4)) dut_full (
        .clk(clk), .rst(rst), .tracking_mode(tracking_mode),
        .pix_valid(b_valid), .pix_sof(b_sof), .pix_data(b_data),
        .max_ready(1'b0), .bram_we(b_we), .bram_waddr(b_waddr),
        .bram_wdata(b_wdata), .static_bram_rdy(b_rdy),
        .frame_err(b_err), .drop_count(b_drop)
    );

    typedef struct {
        logic [18:0] addr;
        logic [3:0]  data;
    } wr_t;

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic        exp_w;
        logic [18:0] exp_a;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[$];
    logic [3:0] mem[N];
    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every bram_we must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bram_we) begin
            we_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h at %0t", bram_waddr, bram_wdata, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("waddr", 32'(bram_waddr), 32'(e.addr));
                check("wdata", 32'(bram_wdata), 32'(e.data));
                if (bram_waddr < 19'(N)) mem[bram_waddr[4:0]] = bram_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] d,
                         input logic exp_w, input logic [18:0] exp_a);
        wr_t e;
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        if (exp_w) begin
            e.addr = exp_a;
            e.data = d;
            sb.push_back(e);
        end
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic build_frame(input int seed);
        vec_t r;
        vecs.delete();
        for (int i = 0; i < N; i++) begin
            r.v     = 1'b1;
            r.s     = (i == 0);
            r.d     = 4'((i + seed) % 16);
            r.exp_w = 1'b1;
            r.exp_a = 19'(i);
            vecs.push_back(r);
        end
    endtask

    task automatic apply_vecs(input int gap_pct);
        foreach (vecs[i]) begin
            while ($urandom_range(99) < gap_pct) tick();
            drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].exp_w, vecs[i].exp_a);
        end
    endtask

    task automatic check_mem(input string name, input int seed);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== 4'((i + seed) % 16)) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        rst = 1'b1;
        tracking_mode = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_data = '0;
        max_ready = 1'b0;
        b_valid = 1'b0;
        b_sof = 1'b0;
        b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_we", 32'(bram_we), 32'd0);
        check("reset_rdy", 32'(static_bram_rdy), 32'd0);
        check("reset_drop", 32'(drop_count), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();

        // 640x480: addresses step by one across line boundaries, mid-frame SOF restarts at 0.
        bad = 0;
        for (int i = 0; i < 700; i++) begin
            b_valid = 1'b1;
            b_sof   = (i == 0);
            b_data  = 4'(i % 16);
            tick();
            if (b_we !== 1'b1 || b_waddr !== 19'(i) || b_wdata !== 4'(i % 16)) bad++;
        end
        check("full_addr_seq", 32'(bad), 32'd0);
        check("full_rdy_low", 32'(b_rdy), 32'd0);
        b_sof = 1'b1;
        tick();
        check("full_err", 32'(b_err), 32'd1);
        check("full_restart_addr", 32'(b_waddr), 32'd0);
        b_valid = 1'b0;
        b_sof = 1'b0;
        tick();

        // Test 1: back-to-back frame.
        for (int i = 0; i < N; i++) mem[i] = 'x;
        base = we_count;
        build_frame(0);
        apply_vecs(0);
        check("t1_last_we", 32'(bram_we), 32'd1);
        check("t1_rdy_at_last_write", 32'(static_bram_rdy), 32'd0);
        tick();
        check("t1_rdy", 32'(static_bram_rdy), 32'd1);
        check("t1_we_count", 32'(we_count - base), 32'(N));
        check_mem("t1_mem", 0);
        max_ready = 1'b1;
        tick();
        check("t1_release", 32'(static_bram_rdy), 32'd0);

        // Test 2: gapped frame with max_ready still high from the last search.
        for (int i = 0; i < N; i++) mem[i] = 'x;
        base = we_count;
        build_frame(3);
        apply_vecs(40);
        tick();
        check("t2_rdy", 32'(static_bram_rdy), 32'd1);
        check("t2_we_count", 32'(we_count - base), 32'(N));
        check_mem("t2_mem", 3);
        repeat (5) tick();
        check("t4_held_level", 32'(static_bram_rdy), 32'd1);
        max_ready = 1'b0;
        tick();
        check("t4_low", 32'(static_bram_rdy), 32'd1);
        max_ready = 1'b1;
        tick();
        check("t4_rise_release", 32'(static_bram_rdy), 32'd0);
        max_ready = 1'b0;

        // Test 3: early SOF after 10 pixels.
        drive(1'b1, 1'b0, 4'h7, 1'b0, '0);
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, 4'(i + 5), 1'b1, 19'(i));
        check("t3_no_err", 32'(frame_err), 32'd0);
        drive(1'b1, 1'b1, 4'hA, 1'b1, 19'd0);
        check("t3_err_pulse", 32'(frame_err), 32'd1);
        drive(1'b1, 1'b0, 4'h1, 1'b1, 19'd1);
        check("t3_err_single", 32'(frame_err), 32'd0);
        for (int i = 2; i < N; i++) drive(1'b1, 1'b0, 4'(i), 1'b1, 19'(i));
        check("t3_rdy_at_last", 32'(static_bram_rdy), 32'd0);
        tick();
        check("t3_rdy", 32'(static_bram_rdy), 32'd1);

        // Test 5: frames dropped in READY, then SOF coincident with release.
        base = we_count;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) drive(1'b1, i == 0, 4'(i), 1'b0, '0);
        end
        check("t5_drop3", 32'(drop_count), 32'd3);
        check("t5_no_writes", 32'(we_count - base), 32'd0);
        max_ready = 1'b1;
        drive(1'b1, 1'b1, 4'h9, 1'b0, '0);
        check("t5_release", 32'(static_bram_rdy), 32'd0);
        check("t5_sof_not_dropped", 32'(drop_count), 32'd3);
        tick();
        drive(1'b1, 1'b0, 4'h2, 1'b0, '0);

        // Test 6: tracking_mode drop at address 17, then async reset mid-frame.
        for (int i = 0; i < 17; i++) drive(1'b1, i == 0, 4'(i), 1'b1, 19'(i));
        tracking_mode = 1'b0;
        drive(1'b1, 1'b0, 4'h3, 1'b0, '0);
        check("t6_rdy_low", 32'(static_bram_rdy), 32'd0);
        tracking_mode = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h4, 1'b0, '0);
        check("t6_drop_held", 32'(drop_count), 32'd3);
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 4'(i + 8), 1'b1, 19'(i));
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_we", 32'(bram_we), 32'd0);
        check("t6_rst_addr", 32'(bram_waddr), 32'd0);
        check("t6_rst_data", 32'(bram_wdata), 32'd0);
        check("t6_rst_drop", 32'(drop_count), 32'd0);
        check("t6_rst_rdy", 32'(static_bram_rdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'h6, 1'b0, '0);
        build_frame(5);
        apply_vecs(20);
        tick();
        check("t6_rdy_after_rst", 32'(static_bram_rdy), 32'd1);

        // drop_count saturation.
        for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 4'h0, 1'b0, '0);
        check("drop_saturate", 32'(drop_count), 32'd255);

        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
